// File: rtl/pixel_array_ctrl.sv
// pixel_array_ctrl: frame sequencer for the 2x2 pixel array.
// Runs erase -> expose -> gap -> convert -> read12 -> read34 -> done,
// generates the 8-bit conversion ramp and captures the four pixel codes.
module pixel_array_ctrl #(
  parameter int ERASE_CYCLES = 5,
  parameter int READ_CYCLES  = 5,
  parameter int EXP_W        = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [EXP_W-1:0] exp_cycles,
  input  logic [7:0]       pix_in1,
  input  logic [7:0]       pix_in2,
  input  logic [7:0]       pix_in3,
  input  logic [7:0]       pix_in4,
  output logic             erase,
  output logic             expose,
  output logic             convert,
  output logic             read12,
  output logic             read34,
  output logic [7:0]       adc_count,
  output logic [7:0]       pix_out1,
  output logic [7:0]       pix_out2,
  output logic [7:0]       pix_out3,
  output logic [7:0]       pix_out4,
  output logic             busy,
  output logic             frame_done
);

  // Shared phase counter is wide enough for exposure, the 256-cycle ramp
  // and both fixed-length phases.
  localparam int W_PH = ($clog2(ERASE_CYCLES + 1) > $clog2(READ_CYCLES + 1)) ?
                        $clog2(ERASE_CYCLES + 1) : $clog2(READ_CYCLES + 1);
  localparam int W_A  = (EXP_W > 8) ? EXP_W : 8;
  localparam int CW   = (W_PH > W_A) ? W_PH : W_A;

  // Counter holds "cycles remaining minus one"; zero marks a phase's last cycle.
  localparam logic [CW-1:0] ERASE_LOAD = CW'(ERASE_CYCLES - 1);
  localparam logic [CW-1:0] READ_LOAD  = CW'(READ_CYCLES - 1);
  localparam logic [CW-1:0] CONV_LOAD  = CW'(255);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERASE,
    ST_EXPOSE,
    ST_GAP,
    ST_CONVERT,
    ST_READ12,
    ST_READ34,
    ST_DONE
  } state_t;

  state_t           state, next_state;
  logic [CW-1:0]    cnt, cnt_d;
  logic [EXP_W-1:0] exp_q;
  logic [CW-1:0]    exp_load;
  logic [7:0]       adc_d;
  logic             last;

  assign last = (cnt == '0);

  // State, phase counter, ramp and latched exposure registers.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      exp_q     <= '0;
      adc_count <= '0;
    end else begin
      state     <= next_state;
      cnt       <= cnt_d;
      adc_count <= adc_d;
      if (state == ST_IDLE && start) begin
        exp_q <= exp_cycles;
      end
    end
  end

  // Next-state, counter reload and Moore control decode.
  // NOTE: every variable gets a default before the case, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    cnt_d      = last ? '0 : cnt - CW'(1);
    adc_d      = '0;
    exp_load   = (exp_q == '0) ? '0 : CW'(exp_q) - CW'(1);
    erase      = 1'b0;
    expose     = 1'b0;
    convert    = 1'b0;
    read12     = 1'b0;
    read34     = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          next_state = ST_ERASE;
          cnt_d      = ERASE_LOAD;
        end
      end
      ST_ERASE: begin
        erase = 1'b1;
        if (last) begin
          next_state = ST_EXPOSE;
          cnt_d      = exp_load;
        end
      end
      ST_EXPOSE: begin
        expose = 1'b1;
        if (last) begin
          next_state = ST_GAP;
          cnt_d      = '0;
        end
      end
      ST_GAP: begin
        next_state = ST_CONVERT;
        cnt_d      = CONV_LOAD;
      end
      ST_CONVERT: begin
        convert = 1'b1;
        if (last) begin
          next_state = ST_READ12;
          cnt_d      = READ_LOAD;
        end else begin
          adc_d = adc_count + 8'd1;
        end
      end
      ST_READ12: begin
        read12 = 1'b1;
        if (last) begin
          next_state = ST_READ34;
          cnt_d      = READ_LOAD;
        end
      end
      ST_READ34: begin
        read34 = 1'b1;
        if (last) begin
          next_state = ST_DONE;
          cnt_d      = '0;
        end
      end
      ST_DONE: begin
        frame_done = 1'b1;
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Capture each pixel pair at the edge that closes its last read cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_out1 <= '0;
      pix_out2 <= '0;
      pix_out3 <= '0;
      pix_out4 <= '0;
    end else begin
      if (state == ST_READ12 && last) begin
        pix_out1 <= pix_in1;
        pix_out2 <= pix_in2;
      end
      if (state == ST_READ34 && last) begin
        pix_out3 <= pix_in3;
        pix_out4 <= pix_in4;
      end
    end
  end

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// tb_pixel_array_ctrl: directed frames checked every cycle against a
// phase-window model of the frame, plus hand-computed literal checkpoints.
module tb_pixel_array_ctrl;

  localparam int EC = 5;
  localparam int RC = 5;
  localparam int EW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [EW-1:0] exp_cycles;
  logic [7:0]    pix_in1, pix_in2, pix_in3, pix_in4;
  logic          erase, expose, convert, read12, read34, busy, frame_done;
  logic [7:0]    adc_count, pix_out1, pix_out2, pix_out3, pix_out4;

  pixel_array_ctrl #(
    .ERASE_CYCLES(EC),
    .READ_CYCLES (RC),
    .EXP_W       (EW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .exp_cycles(exp_cycles),
    .pix_in1   (pix_in1),
    .pix_in2   (pix_in2),
    .pix_in3   (pix_in3),
    .pix_in4   (pix_in4),
    .erase     (erase),
    .expose    (expose),
    .convert   (convert),
    .read12    (read12),
    .read34    (read34),
    .adc_count (adc_count),
    .pix_out1  (pix_out1),
    .pix_out2  (pix_out2),
    .pix_out3  (pix_out3),
    .pix_out4  (pix_out4),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_cnt = 0;
  int base = 0;
  bit cmp_en = 1'b0;

  // Packed view: {erase,expose,convert,read12,read34,busy,frame_done,adc,p1..p4}
  logic [46:0] outs;
  assign outs = {erase, expose, convert, read12, read34, busy, frame_done,
                 adc_count, pix_out1, pix_out2, pix_out3, pix_out4};

  logic [5:0] ctl;
  assign ctl = {erase, expose, convert, read12, read34, busy};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Edge counter: cycle n of a frame is the cycle where edge_cnt == base + n.
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Frame model: offset of the current cycle from the accepting edge.
  bit         m_active;
  int         m_t;
  int         m_e;
  logic [7:0] m_pix [4];

  // Model advances on each edge; capture happens at the edge closing each
  // pair's last read cycle.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0;
      m_t      <= 0;
      m_e      <= 1;
      for (int i = 0; i < 4; i++) m_pix[i] <= 8'h00;
    end else if (m_active) begin
      if (m_t == EC + m_e + 257 + RC) begin
        m_pix[0] <= pix_in1;
        m_pix[1] <= pix_in2;
      end
      if (m_t == EC + m_e + 257 + 2 * RC) begin
        m_pix[2] <= pix_in3;
        m_pix[3] <= pix_in4;
      end
      if (m_t == EC + m_e + 258 + 2 * RC) m_active <= 1'b0;
      else m_t <= m_t + 1;
    end else if (start) begin
      m_active <= 1'b1;
      m_t      <= 1;
      m_e      <= (exp_cycles == '0) ? 1 : int'(exp_cycles);
    end
  end

  function automatic logic [46:0] model_vec();
    logic [6:0] c;
    logic [7:0] a;
    int cf;
    int r1;
    int r3;
    c  = '0;
    a  = '0;
    cf = EC + m_e + 2;
    r1 = cf + 256;
    r3 = r1 + RC;
    if (m_active) begin
      c[1] = 1'b1;
      if (m_t >= 1 && m_t <= EC)                c[6] = 1'b1;
      else if (m_t > EC && m_t <= EC + m_e)     c[5] = 1'b1;
      else if (m_t >= cf && m_t < r1) begin
        c[4] = 1'b1;
        a    = 8'(m_t - cf);
      end
      else if (m_t >= r1 && m_t < r3)           c[3] = 1'b1;
      else if (m_t >= r3 && m_t < r3 + RC)      c[2] = 1'b1;
      else if (m_t == r3 + RC)                  c[0] = 1'b1;
    end
    return {c, a, m_pix[0], m_pix[1], m_pix[2], m_pix[3]};
  endfunction

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) check("outputs_vs_model", outs, model_vec());
  end

  task automatic goto(input int n);
    while (edge_cnt < base + n) @(negedge clk);
  endtask

  task automatic start_frame(input logic [EW-1:0] e);
    @(negedge clk);
    start      = 1'b1;
    exp_cycles = e;
    @(negedge clk);
    start = 1'b0;
    base  = edge_cnt - 1;
  endtask

  task automatic set_pix(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
    pix_in1 = a;
    pix_in2 = b;
    pix_in3 = c;
    pix_in4 = d;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    exp_cycles = '0;
    set_pix(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_state", outs, 47'd0);
    cmp_en = 1'b1;

    // Frame 1: nominal, capture pattern, ignored starts at 100 and 528.
    start_frame(10'd255);
    check("c1_erase", ctl, 6'b100001);
    goto(5);   check("c5_erase", ctl, 6'b100001);
    goto(6);   check("c6_expose", ctl, 6'b010001);
    goto(100); start = 1'b1; check("c100_expose", ctl, 6'b010001);
    goto(101); start = 1'b0;
    goto(260); check("c260_expose", ctl, 6'b010001);
    goto(261); check("c261_gap", {ctl, adc_count}, {6'b000001, 8'd0});
    goto(262); check("c262_conv", {ctl, adc_count}, {6'b001001, 8'd0});
    goto(390); check("c390_adc", adc_count, 8'd128);
    goto(517); check("c517_adc", {ctl, adc_count}, {6'b001001, 8'd255});
    goto(518); check("c518_read12", {ctl, adc_count}, {6'b000101, 8'd0});
    goto(522); set_pix(8'h11, 8'h22, 8'hFF, 8'hFF);
    goto(523); set_pix(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    check("c523_read34", ctl, 6'b000011);
    check("c523_pix12", {pix_out1, pix_out2}, 16'h1122);
    goto(527); set_pix(8'hFF, 8'hFF, 8'h33, 8'h44);
    goto(528); set_pix(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    check("c528_done", frame_done, 1'b1);
    check("c528_pix", {pix_out1, pix_out2, pix_out3, pix_out4}, 32'h11223344);
    start = 1'b1;
    goto(529); start = 1'b0;
    check("c529_idle", {busy, frame_done}, 2'b00);
    goto(531); check("c531_not_queued", busy, 1'b0);

    // Frame 2: exp_cycles=0 -> one expose cycle; mid-frame change ignored.
    start_frame(10'd0);
    goto(3);   exp_cycles = 10'd1023;
    goto(6);   check("e0_c6_expose", ctl, 6'b010001);
    goto(7);   check("e0_c7_gap", ctl, 6'b000001);
    goto(8);   check("e0_c8_conv", {ctl, adc_count}, {6'b001001, 8'd0});
    goto(263); check("e0_c263_adc", adc_count, 8'd255);
    goto(274); check("e0_c274_done", frame_done, 1'b1);
    goto(275); check("e0_c275_idle", busy, 1'b0);

    // Frame 3: exp_cycles=1023.
    start_frame(10'd1023);
    goto(1028); check("e1023_c1028_expose", ctl, 6'b010001);
    goto(1029); check("e1023_c1029_gap", ctl, 6'b000001);
    goto(1030); check("e1023_c1030_conv", ctl, 6'b001001);
    goto(1296); check("e1023_c1296_done", frame_done, 1'b1);
    goto(1297); check("e1023_c1297_idle", busy, 1'b0);

    // Frame 4: reset asserted in the middle of convert.
    start_frame(10'd255);
    goto(300); check("rst_c300_adc", adc_count, 8'd38);
    #2 reset = 1'b1;
    #1 check("rst_immediate", outs, 47'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_idle", outs, 47'd0);

    // Frame 5: nominal frame after reset with capture.
    start_frame(10'd255);
    goto(522); set_pix(8'h11, 8'h22, 8'hFF, 8'hFF);
    goto(523); set_pix(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    goto(527); set_pix(8'hFF, 8'hFF, 8'h33, 8'h44);
    goto(528); set_pix(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    check("f5_c528_done", frame_done, 1'b1);
    check("f5_c528_pix", {pix_out1, pix_out2, pix_out3, pix_out4}, 32'h11223344);
    goto(529); check("f5_c529_idle", busy, 1'b0);
    goto(531);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
